// File: rtl/cp0_intc_pkg.sv
// cp0_intc_pkg: shared CP0 register numbers, exception codes, status bits and FSM encoding
package cp0_intc_pkg;
  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC = 5'd14;
  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam int ST_IE = 0;
  localparam int ST_EXL = 1;
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    lowest_set = 3'd0;
    for (int j = 7; j >= 0; j--) if (v[j]) lowest_set = 3'(j);
  endfunction
endpackage

// File: rtl/cp0_intc_int_sync_edge.sv
// int_sync_edge: two-flop synchroniser plus registered rising-edge pulse for one interrupt line
module int_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);
  logic s1, s2, s3;
  always_ff @(posedge clk or negedge reset)
    if (!reset) {s1, s2, s3, rise} <= 4'b0;
    else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
      rise <= s2 & ~s3;
    end
endmodule

// File: rtl/cp0_intc.sv
// cp0_intc: CP0 Status/Cause/EPC registers and prioritised interrupt controller
module cp0_intc
  import cp0_intc_pkg::*;
#(
  parameter int N_INT = 8,
  parameter logic [31:0] VEC_BASE = 32'h0000_0004,
  parameter logic [31:0] SYS_VEC = 32'h0000_0024
) (
  input  logic clk,
  input  logic reset,
  input  logic [N_INT-1:0] int_src,
  output logic Ireq,
  input  logic Iack,
  input  logic WriteEPC,
  input  logic WriteCause,
  input  logic sysCause,
  input  logic WriteCp0,
  input  logic eret,
  input  logic [4:0] c0_addr,
  input  logic [31:0] c0_wdata,
  input  logic [31:0] epc_wdata,
  output logic [31:0] c0_rdata,
  output logic [31:0] epc_out,
  output logic [31:0] vector_out,
  output logic [N_INT-1:0] int_pending
);
  localparam logic [7:0] LINES = 8'((9'd1 << N_INT) - 9'd1);
  state_t state, state_n;
  logic ie, exl, last_sys, any, iack_hit, sys_hit, eret_hit;
  logic [7:0] im, pend, act, rise8, sw, clr;
  logic [4:0] exc;
  logic [2:0] idx, sel;
  logic [31:0] epc;
  logic [N_INT-1:0] rise;
  genvar i;
  for (i = 0; i < N_INT; i++) begin : g_sync
    int_sync_edge u_sync (.clk(clk), .reset(reset), .d(int_src[i]), .rise(rise[i]));
  end
  assign rise8 = 8'(rise);
  // software interrupt bits Cause[9:8] feed pending[1:0]
  assign sw = (WriteCp0 && c0_addr == CP0_CAUSE) ? {6'b0, c0_wdata[9:8]} : 8'b0;
  assign act = pend & im;
  assign any = |act;
  assign sel = lowest_set(act);
  assign iack_hit = state == REQ && Iack;
  assign sys_hit = state == IDLE && WriteCause && sysCause;
  assign eret_hit = state == SERVICE && eret;
  assign clr = iack_hit ? 8'b1 << sel : 8'b0;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: state_n = sys_hit ? SERVICE : (ie && !exl && any) ? REQ : IDLE;
      REQ: state_n = Iack ? SERVICE : (!ie || !any) ? IDLE : REQ;
      SERVICE: state_n = eret ? IDLE : SERVICE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      Ireq <= 1'b0;
      pend <= 8'b0;
      {ie, exl, last_sys} <= 3'b0;
      im <= 8'b0;
      exc <= 5'b0;
      idx <= 3'b0;
      epc <= 32'b0;
    end else begin
      state <= state_n;
      Ireq <= state_n == REQ;
      pend <= (pend | rise8 | sw) & ~clr & LINES;
      if (WriteCp0 && c0_addr == CP0_STATUS) begin
        ie <= c0_wdata[ST_IE];
        exl <= c0_wdata[ST_EXL];
        im <= c0_wdata[15:8];
      end
      if (eret_hit) {exl, ie} <= 2'b01;
      // exception entry overrides any same-cycle mtc0 of Status
      if (sys_hit || iack_hit) {exl, ie} <= 2'b10;
      if (WriteEPC) epc <= epc_wdata;
      else if (WriteCp0 && c0_addr == CP0_EPC) epc <= c0_wdata;
      if (WriteCause && sysCause) begin
        exc <= EXC_SYS;
        last_sys <= 1'b1;
      end else if (iack_hit || WriteCause) begin
        exc <= EXC_INT;
        idx <= sel;
        last_sys <= 1'b0;
      end
    end
  assign c0_rdata = c0_addr == CP0_STATUS ? {16'b0, im, 6'b0, exl, ie} :
                    c0_addr == CP0_CAUSE ? {13'b0, idx, pend, 1'b0, exc, 2'b0} :
                    c0_addr == CP0_EPC ? epc : 32'b0;
  assign vector_out = state == REQ ? VEC_BASE + {27'b0, sel, 2'b0} :
                      last_sys ? SYS_VEC : VEC_BASE + {27'b0, idx, 2'b0};
  assign epc_out = epc;
  assign int_pending = pend[N_INT-1:0];
endmodule

// File: tb/tb_cp0_intc.sv
// tb_cp0_intc: directed scoreboard bench for the CP0 interrupt controller
module tb_cp0_intc;
  localparam int RD = 0, IRQ = 1, VEC = 2, EPC = 3, PND = 4, VQ = 5;
  logic clk = 0, reset = 0;
  logic [7:0] int_src = 0;
  logic Iack = 0, WriteEPC = 0, WriteCause = 0, sysCause = 0, WriteCp0 = 0, eret = 0;
  logic [4:0] c0_addr = 0;
  logic [31:0] c0_wdata = 0, epc_wdata = 0;
  logic Ireq;
  logic [31:0] c0_rdata, epc_out, vector_out;
  logic [7:0] int_pending;
  typedef struct {string tag; int sig; logic [31:0] exp;} chk_t;
  chk_t q[$];
  logic [31:0] vq[$];
  int n_chk = 0, n_fail = 0;
  logic ireq_q = 0;

  cp0_intc dut (
    .clk(clk), .reset(reset), .int_src(int_src), .Ireq(Ireq), .Iack(Iack),
    .WriteEPC(WriteEPC), .WriteCause(WriteCause), .sysCause(sysCause),
    .WriteCp0(WriteCp0), .eret(eret), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
    .epc_wdata(epc_wdata), .c0_rdata(c0_rdata), .epc_out(epc_out),
    .vector_out(vector_out), .int_pending(int_pending)
  );

  always #5 clk = ~clk;

  // monitor: drains expected checks and matches every new Ireq against the expected vector queue
  always @(negedge clk) begin
    chk_t c;
    logic [31:0] act, e;
    while (q.size() != 0) begin
      c = q.pop_front();
      act = c.sig == RD ? c0_rdata : c.sig == IRQ ? {31'b0, Ireq} : c.sig == VEC ? vector_out :
            c.sig == EPC ? epc_out : c.sig == PND ? 32'(int_pending) : 32'(vq.size());
      n_chk++;
      if (act !== c.exp) begin
        n_fail++;
        $display("FAIL %s: got %h, expected %h", c.tag, act, c.exp);
      end
    end
    if (Ireq && !ireq_q) begin
      n_chk++;
      if (vq.size() == 0) begin
        n_fail++;
        $display("FAIL ireq_unexpected: got request with vector %h, expected none", vector_out);
      end else begin
        e = vq.pop_front();
        if (vector_out !== e) begin
          n_fail++;
          $display("FAIL ireq_vector: got %h, expected %h", vector_out, e);
        end
      end
    end
    ireq_q = Ireq;
  end

  task automatic chk(input string tag, input int sig, input logic [31:0] exp);
    chk_t c;
    c.tag = tag;
    c.sig = sig;
    c.exp = exp;
    q.push_back(c);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    WriteCp0 = 1; c0_addr = a; c0_wdata = d;
    tick;
    WriteCp0 = 0;
  endtask
  task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] e);
    c0_addr = a;
    chk(tag, RD, e);
    tick;
  endtask
  task automatic ack;
    Iack = 1; tick; Iack = 0;
  endtask
  task automatic do_eret;
    eret = 1; tick; eret = 0;
  endtask

  initial begin
    repeat (3) tick;
    reset = 1;
    tick;
    chk("rst_ireq", IRQ, 0); chk("rst_vec", VEC, 32'h4);
    rd("rst_status", 12, 0); rd("rst_cause", 13, 0); rd("rst_epc", 14, 0);
    // single interrupt on line 3
    mtc0(12, 32'h0000_FF01);
    int_src = 8'h08;
    vq.push_back(32'h10);
    repeat (3) tick;
    chk("lat_pnd_k2", PND, 0); chk("lat_irq_k2", IRQ, 0);
    tick;
    chk("lat_pnd_k3", PND, 8'h08); chk("lat_irq_k3", IRQ, 0);
    tick;
    chk("lat_irq_k4", IRQ, 1); chk("single_vec", VEC, 32'h10);
    ack;
    chk("ack_irq", IRQ, 0); chk("ack_pnd", PND, 0); chk("ack_vec", VEC, 32'h10);
    rd("ack_status", 12, 32'h0000_FF02);
    rd("ack_cause", 13, 32'h0003_0000);
    int_src = 0;
    repeat (3) tick;
    // priority: lines 5 and 2 together
    int_src = 8'h24;
    repeat (5) tick;
    chk("pri_pnd", PND, 8'h24); chk("pri_svc_irq", IRQ, 0);
    vq.push_back(32'hC);
    do_eret;
    chk("pri_eret_irq", IRQ, 0);
    tick;
    chk("pri_irq1", IRQ, 1); chk("pri_vec1", VEC, 32'hC);
    ack;
    chk("pri_pnd2", PND, 8'h20); chk("pri_vec_ack1", VEC, 32'hC);
    vq.push_back(32'h18);
    do_eret;
    tick;
    chk("pri_irq2", IRQ, 1); chk("pri_vec2", VEC, 32'h18);
    ack;
    chk("pri_pnd3", PND, 0);
    rd("pri_cause", 13, 32'h0005_0000);
    do_eret;
    int_src = 0;
    // masking and withdrawal
    mtc0(12, 32'h0000_0001);
    repeat (3) tick;
    int_src = 8'h40;
    repeat (6) tick;
    chk("mask_pnd", PND, 8'h40); chk("mask_irq", IRQ, 0);
    vq.push_back(32'h1C);
    mtc0(12, 32'h0000_4001);
    chk("unmask_irq0", IRQ, 0);
    tick;
    chk("unmask_irq1", IRQ, 1); chk("unmask_vec", VEC, 32'h1C);
    mtc0(12, 32'h0000_4000);
    chk("wd_irq_hold", IRQ, 1);
    tick;
    chk("wd_irq_drop", IRQ, 0); chk("wd_pnd", PND, 8'h40);
    rd("wd_status", 12, 32'h0000_4000);
    // syscall while line 6 stays pending
    WriteEPC = 1; epc_wdata = 32'h100; WriteCause = 1; sysCause = 1;
    tick;
    WriteEPC = 0; WriteCause = 0; sysCause = 0;
    chk("sys_epc", EPC, 32'h100); chk("sys_vec", VEC, 32'h24); chk("sys_irq", IRQ, 0);
    rd("sys_cause", 13, 32'h0005_4020);
    rd("sys_status", 12, 32'h0000_4002);
    rd("sys_epc_rd", 14, 32'h100);
    repeat (3) tick;
    chk("sys_irq_hold", IRQ, 0);
    vq.push_back(32'h1C);
    do_eret;
    chk("sys_eret_irq", IRQ, 0); chk("sys_eret_vec", VEC, 32'h24);
    tick;
    chk("sys_irq_after", IRQ, 1); chk("sys_vec_after", VEC, 32'h1C);
    ack;
    chk("sys_ack_pnd", PND, 0); chk("sys_ack_vec", VEC, 32'h1C);
    rd("sys_ack_cause", 13, 32'h0006_0000);
    // EPC write priority, software interrupt, unmapped register
    mtc0(14, 32'h500);
    chk("mtc0_epc", EPC, 32'h500);
    WriteCp0 = 1; c0_addr = 14; c0_wdata = 32'h600; WriteEPC = 1; epc_wdata = 32'h300;
    tick;
    WriteCp0 = 0; WriteEPC = 0;
    chk("epc_prio", EPC, 32'h300);
    mtc0(13, 32'h0000_0200);
    chk("sw_pnd", PND, 8'h02);
    rd("sw_cause", 13, 32'h0006_0200);
    mtc0(5, 32'hFFFF_FFFF);
    rd("unmapped_rd", 5, 0);
    // asynchronous reset in SERVICE with pending[1] set
    reset = 0;
    c0_addr = 12;
    chk("arst_status", RD, 0); chk("arst_epc", EPC, 0); chk("arst_pnd", PND, 0);
    chk("arst_irq", IRQ, 0); chk("arst_vec", VEC, 32'h4);
    tick;
    rd("arst_cause", 13, 0);
    rd("arst_epc_rd", 14, 0);
    reset = 1;
    repeat (2) tick;
    chk("all_irqs_seen", VQ, 0);
    repeat (2) tick;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cp0_intc.md
Name: cp0_intc

Overview:
- Coprocessor-0 register file and interrupt controller for the multicycle MIPS core.
- Sits beside the control FSM. Synchronises and latches external interrupt lines, then raises Ireq toward the FSM and consumes its Iack, WriteEPC, WriteCause, WriteCp0 and sysCause strobes.
- Holds Status, Cause and EPC, serves mfc0 reads, and supplies the exception vector for PCSource=100 and EPC for PCSource=101 (eret).

Parameters:
- N_INT, 8, number of external interrupt lines (1..8).
- VEC_BASE, 32'h0000_0004, base of the interrupt vector table; each entry is 4 bytes.
- SYS_VEC, 32'h0000_0024, syscall entry address.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- int_src  in  N_INT  external interrupt lines; rising-edge triggered; asynchronous to clk.
- Ireq  out  1  registered interrupt request to the control FSM.
- Iack  in  1  one-cycle acknowledge from the FSM on interrupt entry.
- WriteEPC  in  1  load EPC from epc_wdata.
- WriteCause  in  1  load Cause (ExcCode/index).
- sysCause  in  1  qualifies WriteCause: 1 = syscall, 0 = interrupt.
- WriteCp0  in  1  mtc0 write strobe.
- eret  in  1  one-cycle strobe in the EX_ERET state.
- c0_addr  in  5  CP0 register number (Inst[15:11]).
- c0_wdata  in  32  mtc0 data ($rt).
- epc_wdata  in  32  ALU result for EPC.
- c0_rdata  out  32  combinational mfc0 read data.
- epc_out  out  32  current EPC.
- vector_out  out  32  exception entry address.
- int_pending  out  N_INT  debug view of the pending latch.

Behaviour:
- Registers:
  - Status (addr 12): bit0 IE, bit1 EXL, bits[15:8] IM; other bits read 0.
  - Cause (addr 13): bits[15:8] IP (= pending), bits[6:2] ExcCode (0 = Int, 8 = Sys), bits[18:16] serviced index.
  - EPC (addr 14).
  - All other addresses read 0; writes to them are ignored.
- Reset (reset=0, asynchronous): Status=0, Cause=0, EPC=0, pending=0, sync flops=0, Ireq=0, state=IDLE. vector_out=VEC_BASE and c0_rdata=0 follow from these values.
- Input path:
  - Two-flop synchroniser per line, then a registered previous-value for edge detection.
  - A rising edge sets pending[i] on the following clock.
  - Latency: int_src rising before edge k gives pending at edge k+3 and Ireq at edge k+4.
- Arbitration: lowest index has highest priority. sel = lowest i with pending[i] & IM[i].
- FSM states:
  - IDLE → REQ when IE=1, EXL=0 and (pending & IM)≠0; Ireq<=1.
  - REQ: if IE or the masked pending set drops to zero before Iack, then Ireq<=0 and return to IDLE (withdrawal). On Iack: Ireq<=0, clear pending[sel], EXL<=1, IE<=0, go to SERVICE.
  - SERVICE: on eret, EXL<=0, IE<=1, go to IDLE. Ireq stays 0 throughout.
  - IDLE with WriteCause & sysCause (syscall): EXL<=1, IE<=0, go to SERVICE.
- vector_out:
  - In REQ: VEC_BASE + 4*sel.
  - After Iack: VEC_BASE + 4*Cause[18:16].
  - When the last event was a syscall: SYS_VEC.
- Cause writes:
  - WriteCause & !sysCause: ExcCode<=0, index<=sel.
  - WriteCause & sysCause: ExcCode<=8.
- EPC write: WriteEPC loads EPC<=epc_wdata.
- mtc0:
  - WriteCp0 writes addr 12 (IE, EXL, IM) and addr 14 (EPC).
  - Writes to Cause affect only bits [9:8] (software interrupts); these OR into the pending set.
- Simultaneous events:
  - A new edge in the same cycle as Iack is latched; only pending[sel] clears.
  - WriteCp0 and Iack in the same cycle: the Iack update of IE/EXL wins.
  - WriteEPC has priority over an mtc0 EPC write in the same cycle.
- Reset mid-REQ or mid-SERVICE: everything returns to reset values immediately, and pending interrupts are discarded.

Decomposition:
- Shared package holds:
  - CP0 register numbers 12/13/14.
  - ExcCode constants EXC_INT=0 and EXC_SYS=8.
  - Status bit positions.
  - FSM state encoding IDLE/REQ/SERVICE.
- One natural sub-module: int_sync_edge, the per-line 2-flop synchroniser plus rising-edge detector, instantiated N_INT times.

Test Plan:
- Reset and readback: release reset, then mfc0 of 12/13/14 → all 0; Ireq=0; vector_out=32'h4.
- Single interrupt: mtc0 Status=32'h0000_FF01, pulse int_src[3] → Ireq=1 four edges later; vector_out=32'h10. Iack → Ireq=0, Status.IE=0, Status.EXL=1, Cause[18:16]=3, pending[3]=0.
- Priority: int_src[5] and int_src[2] rise together → sel=2, vector=32'hC. After eret, second Ireq with vector=32'h18.
- Masking and withdrawal: IM=0 → edges latch but Ireq stays 0. Unmask → Ireq asserts. mtc0 IE=0 while in REQ → Ireq drops next edge, FSM back to IDLE, pending retained.
- Syscall: WriteEPC with epc_wdata=32'h0000_0100, plus WriteCause and sysCause → EPC=32'h100, ExcCode=8, vector_out=32'h24, Ireq suppressed until eret restores IE=1.
- Asynchronous reset asserted in SERVICE with pending[1]=1 → immediately Status=Cause=EPC=0, pending=0, Ireq=0.
